// File: rtl/me_frame_sequencer.sv
// Motion-estimation frame sequencer: raster walk over a runtime-sized block grid.
// Optional feature macro: ME_ABORT_EN adds an abort input that cancels a frame.
module me_frame_sequencer #(
    parameter int BX_W     = 7,
    parameter int BY_W     = 7,
    parameter int NUM_PASS = 1,
    parameter int PASS_W   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [BX_W-1:0]      blocks_x_m1,
    input  logic [BY_W-1:0]      blocks_y_m1,
    input  logic                 firstframe,
    input  logic                 currentfilled,
    input  logic                 blockend,
`ifdef ME_ABORT_EN
    input  logic                 abort,
`endif
    output logic [BY_W+BX_W-1:0] curpos,
    output logic [PASS_W-1:0]    pass_idx,
    output logic                 SWaddren,
    output logic                 sw_restart,
    output logic                 MVArray_WE,
    output logic                 UPen,
    output logic                 rowend,
    output logic                 frameend,
    output logic                 frame_done,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE, BLK_INIT, FIRST, FILL_CUR, PROCESS, DONE
    } state_t;

    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASS - 1);

    state_t            state, nxt;
    logic [BX_W-1:0]   col, xm1;
    logic [BY_W-1:0]   row, ym1;
    logic [PASS_W-1:0] pass_q;
    logic              restart_q;
    logic              kill, last_pass, last_blk, advance, pass_step;

`ifdef ME_ABORT_EN
    assign kill = abort && (state != IDLE);
`else
    assign kill = 1'b0;
`endif

    assign last_pass = (pass_q == LAST_PASS);
    assign last_blk  = (col == xm1) && (row == ym1);
    // Strobes are suppressed on a reset or abort edge.
    assign advance   = !reset && !kill &&
                       ((state == FIRST) ||
                        (state == PROCESS && blockend && last_pass));
    assign pass_step = !kill && (state == PROCESS) && blockend && !last_pass;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (kill) begin
            nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:     if (enable) nxt = BLK_INIT;
                BLK_INIT: nxt = firstframe ? FIRST : FILL_CUR;
                FIRST:    if (last_blk) nxt = DONE;
                FILL_CUR: if (currentfilled) nxt = PROCESS;
                PROCESS:  if (blockend && last_pass)
                              nxt = last_blk ? DONE : BLK_INIT;
                DONE:     nxt = IDLE;
                default:  nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            xm1       <= '0;
            ym1       <= '0;
            pass_q    <= '0;
            restart_q <= 1'b0;
        end else if (kill) begin
            col       <= '0;
            row       <= '0;
            pass_q    <= '0;
            restart_q <= 1'b0;
        end else begin
            restart_q <= (state == FILL_CUR && currentfilled) || pass_step;
            if (state == IDLE && enable) begin
                xm1    <= blocks_x_m1;
                ym1    <= blocks_y_m1;
                col    <= '0;
                row    <= '0;
                pass_q <= '0;
            end else if (state == DONE) begin
                col    <= '0;
                row    <= '0;
                pass_q <= '0;
            end else if (advance) begin
                pass_q <= '0;
                if (col != xm1) begin
                    col <= col + BX_W'(1);
                end else begin
                    col <= '0;
                    row <= (row == ym1) ? '0 : row + BY_W'(1);
                end
            end else if (state == FILL_CUR && currentfilled) begin
                pass_q <= '0;
            end else if (pass_step) begin
                pass_q <= pass_q + PASS_W'(1);
            end
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        curpos     = {row, col};
        pass_idx   = pass_q;
        SWaddren   = (state == PROCESS);
        sw_restart = restart_q;
        MVArray_WE = advance;
        UPen       = advance;
        rowend     = advance && (col == xm1);
        frameend   = busy && last_blk;
        frame_done = (state == DONE) && !reset && !kill;
    end

endmodule
